// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_cla_adder
// Brief    : Pipelined carry-look-ahead adder/subtractor. It resolves one
//            GROUP-bit CLA slice per stage and registers the carry between
//            stages.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             SUB,
    output logic             out_valid,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             OVF
);

    localparam int N = WIDTH / GROUP;

    if (GROUP < 1 || (WIDTH % GROUP) != 0 || WIDTH < 1) begin : g_bad_params
        $error("pipelined_cla_adder: WIDTH must be a positive multiple of GROUP");
    end

    // Returns {carry_out, sum}. Each carry is a flat sum of generate/propagate
    // products, so there is no ripple path through the slice.
    function automatic logic [GROUP:0] f_cla(input logic [GROUP-1:0] a,
                                             input logic [GROUP-1:0] b,
                                             input logic             cin);
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             t;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < GROUP; i++) begin
            t = cin;
            for (int m = 0; m <= i; m++) t = t & p[m];
            c[i+1] = t;
            for (int j = 0; j <= i; j++) begin
                t = g[j];
                for (int m = j + 1; m <= i; m++) t = t & p[m];
                c[i+1] = c[i+1] | t;
            end
        end
        return {c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

    logic [WIDTH-1:0] w_b_eff;
    logic             w_c_eff;
    assign w_b_eff = SUB ? ~B : B;
    assign w_c_eff = SUB ? 1'b1 : CIN;

    // Intermediate stages carry the completed low sum and the still-unprocessed
    // high operand bits, shifted down so that the next slice is always at bit 0.
    for (genvar s = 0; s < N - 1; s++) begin : g_stage
        localparam int DONE = (s + 1) * GROUP;
        localparam int REM  = WIDTH - DONE;

        logic             v_q, v_d;
        logic [DONE-1:0]  sum_q, sum_d;
        logic [REM-1:0]   a_q, a_d, b_q, b_d;
        logic             c_q, c_d;
        logic [GROUP:0]   w_r;

        if (s == 0) begin : g_first
            assign w_r   = f_cla(A[GROUP-1:0], w_b_eff[GROUP-1:0], w_c_eff);
            assign sum_d = w_r[GROUP-1:0];
            assign a_d   = A[WIDTH-1:GROUP];
            assign b_d   = w_b_eff[WIDTH-1:GROUP];
            assign v_d   = in_valid;
        end else begin : g_next
            assign w_r   = f_cla(g_stage[s-1].a_q[GROUP-1:0],
                                 g_stage[s-1].b_q[GROUP-1:0], g_stage[s-1].c_q);
            assign sum_d = {w_r[GROUP-1:0], g_stage[s-1].sum_q};
            assign a_d   = g_stage[s-1].a_q[WIDTH-s*GROUP-1:GROUP];
            assign b_d   = g_stage[s-1].b_q[WIDTH-s*GROUP-1:GROUP];
            assign v_d   = g_stage[s-1].v_q;
        end
        assign c_d = w_r[GROUP];

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q   <= 1'b0;
                sum_q <= '0;
                a_q   <= '0;
                b_q   <= '0;
                c_q   <= 1'b0;
            end else if (!hold) begin
                v_q   <= v_d;
                sum_q <= sum_d;
                a_q   <= a_d;
                b_q   <= b_d;
                c_q   <= c_d;
            end
        end
    end

    logic [GROUP-1:0] w_fa, w_fb;
    logic             w_fc, w_fv;
    logic [GROUP:0]   w_fr;
    logic [WIDTH-1:0] w_s_d;
    logic             w_ovf;

    if (N == 1) begin : g_single
        assign w_fa  = A[GROUP-1:0];
        assign w_fb  = w_b_eff[GROUP-1:0];
        assign w_fc  = w_c_eff;
        assign w_fv  = in_valid;
        assign w_s_d = w_fr[GROUP-1:0];
    end else begin : g_multi
        assign w_fa  = g_stage[N-2].a_q;
        assign w_fb  = g_stage[N-2].b_q;
        assign w_fc  = g_stage[N-2].c_q;
        assign w_fv  = g_stage[N-2].v_q;
        assign w_s_d = {w_fr[GROUP-1:0], g_stage[N-2].sum_q};
    end

    assign w_fr  = f_cla(w_fa, w_fb, w_fc);
    // The carry into the MSB is recovered as a ^ b ^ sum at that bit.
    assign w_ovf = (w_fa[GROUP-1] ^ w_fb[GROUP-1] ^ w_fr[GROUP-1]) ^ w_fr[GROUP];

    logic             out_valid_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q, ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (!hold) begin
            out_valid_q <= w_fv;
            if (w_fv) begin
                s_q    <= w_s_d;
                cout_q <= w_fr[GROUP];
                ovf_q  <= w_ovf;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign COUT      = cout_q;
    assign OVF       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// Testbench for pipelined_cla_adder: random and directed ops checked by a
// scoreboard against an arithmetic reference model.
module tb_pipelined_cla_adder;

    localparam int WIDTH = 16;
    localparam int GROUP = 4;
    localparam int LAT   = WIDTH / GROUP;

    logic             clk = 1'b0;
    logic             rst, hold, in_valid, CIN, SUB;
    logic [WIDTH-1:0] A, B;
    logic             out_valid, COUT, OVF;
    logic [WIDTH-1:0] S;

    pipelined_cla_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
        .clk(clk), .rst(rst), .hold(hold), .in_valid(in_valid),
        .A(A), .B(B), .CIN(CIN), .SUB(SUB),
        .out_valid(out_valid), .S(S), .COUT(COUT), .OVF(OVF)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
        int               adv;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   adv    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation's meaning.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        exp_t          e;
        logic [WIDTH:0] u;
        int            sa, sb, full;
        sa   = int'($signed(a));
        sb   = int'($signed(b));
        full = sub ? sa - sb : sa + sb + int'(cin);
        u    = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin});
        e.s  = u[WIDTH-1:0];
        e.c  = sub ? (a >= b) : u[WIDTH];
        e.o  = (full > 32767) || (full < -32768);
        e.adv = 0;
        return e;
    endfunction

    // Scoreboard tap (at the edge) and monitor (1 time unit later).
    logic             last_v, last_c, last_o;
    logic [WIDTH-1:0] last_s;
    initial begin
        last_v = 1'b0; last_s = '0; last_c = 1'b0; last_o = 1'b0;
    end

    always @(posedge clk) begin
        logic h, r;
        exp_t e;
        h = hold;
        r = rst;
        if (r) begin
            q.delete();
        end else if (!h) begin
            adv++;
            if (in_valid) begin
                e     = model(A, B, CIN, SUB);
                e.adv = adv;
                q.push_back(e);
            end
        end
        #1;
        if (r) begin
            chk("reset_valid", 32'(out_valid), 32'd0);
            chk("reset_S", 32'(S), 32'd0);
            chk("reset_flags", {30'd0, COUT, OVF}, 32'd0);
        end else if (h) begin
            chk("hold_stable", {out_valid, COUT, OVF, 13'd0, S},
                {last_v, last_c, last_o, 13'd0, last_s});
        end else if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 32'(S), 32'hDEAD);
            end else begin
                e = q.pop_front();
                chk("S", 32'(S), 32'(e.s));
                chk("COUT", 32'(COUT), 32'(e.c));
                chk("OVF", 32'(OVF), 32'(e.o));
                chk("latency", 32'(adv - e.adv), 32'(LAT - 1));
            end
        end else begin
            chk("bubble_keeps_outputs", {COUT, OVF, 14'd0, S}, {last_c, last_o, 14'd0, last_s});
        end
        last_v = out_valid; last_s = S; last_c = COUT; last_o = OVF;
    end

    task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic sub);
        in_valid = 1'b1; A = a; B = b; CIN = cin; SUB = sub;
        @(negedge clk);
    endtask

    task automatic bubble(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            A = WIDTH'($urandom); B = WIDTH'($urandom);
            CIN = 1'($urandom); SUB = 1'($urandom);
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; in_valid = 1'b1;
        A = '1; B = '1; CIN = 1'b0; SUB = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b0;
            @(negedge clk);
            chk("post_reset_valid", 32'(out_valid), 32'd0);
            chk("post_reset_S", 32'(S), 32'd0);
        end

        // Directed corner cases
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        op(16'h8000, 16'h8000, 1'b0, 1'b0);
        op(16'h0005, 16'h0007, 1'b1, 1'b1);
        op(16'h8000, 16'h0001, 1'b0, 1'b1);
        op(16'h1234, 16'h8000, 1'b0, 1'b1);
        op(16'h0000, 16'h0000, 1'b1, 1'b1);
        bubble(1);

        // Streaming with one bubble
        for (int i = 0; i < 10; i++) op(WIDTH'(i), WIDTH'(3 * i), 1'b0, 1'b0);
        bubble(1);
        op(16'h1111, 16'h1111, 1'b0, 1'b0);
        bubble(LAT + 1);

        // Random traffic with random stalls
        for (int i = 0; i < 300; i++) begin
            hold     = ($urandom_range(0, 9) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            A = WIDTH'($urandom); B = WIDTH'($urandom);
            CIN = 1'($urandom); SUB = 1'($urandom);
            @(negedge clk);
        end
        hold = 1'b0;
        bubble(LAT + 1);

        // Hold mid-flight, then release
        op(16'h0101, 16'h0202, 1'b0, 1'b0);
        op(16'h7000, 16'h7000, 1'b1, 1'b0);
        op(16'h0003, 16'h0009, 1'b0, 1'b1);
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; A = WIDTH'($urandom); B = WIDTH'($urandom);
            @(negedge clk);
        end
        hold = 1'b0;
        bubble(LAT + 2);

        // Reset during hold flushes everything in flight
        op(16'hAAAA, 16'h5555, 1'b0, 1'b0);
        op(16'h0001, 16'h0002, 1'b0, 1'b1);
        op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        hold = 1'b1;
        bubble(2);
        rst = 1'b1;
        bubble(1);
        rst = 1'b0; hold = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            bubble(1);
            chk("flush_valid", 32'(out_valid), 32'd0);
        end

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
